approx_adder_error_eval: RTL and testbench
==========================================

# approx_adder_error_eval

Sequential error-evaluation harness for the 8-bit approximate adders in the `adder_i16_o9` family. It drives every one of the 2^16 operand pairs into the combinational adder under test and reads back its 9-bit result. Each result is compared against the exact sum, and error statistics are accumulated: error count, max/mean-error numerator, signed bias and worst-case pair. It sits at the output end of the adder interface, as the consumer/checker, wrapping any `_appN` netlist for on-chip or simulation QoR measurement.

## Interface
- `WIDTH`, 8: operand width. The result is `WIDTH+1` bits and the sweep has 2^(2·WIDTH) pairs. Accumulator widths below are given for `WIDTH`=8.
- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `start` input, 1 bit: begin a sweep. Sampled only in IDLE or DONE.
- `en` input, 1 bit: advance enable. Low in RUN freezes the counter and the accumulators.
- `op_a` output, 8 bits: operand A to the DUT. Bit 7 wires to DUT pin `g0`, bit 0 to `g7`.
- `op_b` output, 8 bits: operand B to the DUT. Bit 7 wires to `g8`, bit 0 to `g15`.
- `approx_sum` input, 9 bits: DUT result. Bit 8 = `g123` (carry out), bit 0 = `g115`.
- `busy` output, 1 bit: high in RUN.
- `done` output, 1 bit: high in DONE.
- `err_count` output, 17 bits: number of pairs with approx ≠ exact.
- `max_abs_err` output, 9 bits: maximum |exact − approx|.
- `sum_abs_err` output, 25 bits: Σ|exact − approx|.
- `sum_err` output, 26 bits, signed: Σ(exact − approx).
- `worst_a` output, 8 bits: A of the first pair reaching `max_abs_err`.
- `worst_b` output, 8 bits: B of the same pair.

## Operation
- State register IDLE / RUN / DONE. A 16-bit pair counter `idx` drives the operands: `op_a` = `idx[15:8]`, `op_b` = `idx[7:0]`. Both are register outputs; the DUT path is combinational back into `approx_sum`.
- Error computation:
  - exact = zero-extend(`op_a`) + zero-extend(`op_b`), 9 bits, no overflow.
  - e = exact − `approx_sum`, signed 10 bits.
  - |e| is in the range 0..511.
- IDLE, `start`=1:
  - Clear `idx` and all accumulators.
  - Clear `worst_a`/`worst_b`.
  - Go to RUN.
- RUN, `en`=1, per cycle:
  - Fold e for the current `idx` into the accumulators.
  - `err_count` += (e≠0).
  - `sum_abs_err` += |e|.
  - `sum_err` += e.
  - If |e| > `max_abs_err` (strictly greater), update `max_abs_err` and capture `worst_a`/`worst_b`. Ties keep the earliest pair.
  - Then `idx`++.
- RUN, `en`=1 with `idx`=0xFFFF: accumulate the last pair, `idx` wraps to 0, go to DONE.
- RUN, `en`=0: no state change. `op_a`/`op_b` hold, so `approx_sum` must be stable.
- RUN, `start`: ignored.
- DONE: accumulators and worst pair are held stable. `start`=1 behaves exactly as from IDLE (clear, go to RUN).
- Accumulators never saturate. Widths are sized for the full sweep worst case, e.g. 65536·511 < 2^25.

## Timing
- Reset (`rst`=1 at an edge):
  - State IDLE, `idx`=0, so `op_a`=`op_b`=0.
  - `busy`=0, `done`=0.
  - All statistics outputs 0.
  - This overrides `start` and `en` in the same cycle.
  - Reset mid-RUN discards the partial sweep.
- `start` sampled at edge T0: `busy`=1 from T0, with pair 0 presented.
- Pair k (`en` continuously high) is accumulated at edge T0+k+1.
- `done`=1 and `busy`=0 from edge T0+65536 onward. Total latency is 65536 cycles plus the number of `en`-low cycles in RUN.
- Statistics outputs are registers. They update at each accumulating edge and are final when `done` rises.
- Restart from DONE: `done` drops and `busy` rises at the same edge.

## Test plan
- Exact DUT model (approx = a+b), `en`=1 → `done` at T0+65536. `err_count`=0, `max_abs_err`=0, `sum_abs_err`=0, `sum_err`=0, `worst_a`=`worst_b`=0.
- Truncated DUT (approx = (a+b) & ~7) → `err_count`=57344, `max_abs_err`=7, `sum_abs_err`=229376, `sum_err`=229376, `worst_a`=0, `worst_b`=7.
- Stuck-at-zero DUT (approx = 0) → `err_count`=65535, `max_abs_err`=510, `sum_abs_err`=`sum_err`=16711680, `worst_a`=`worst_b`=255.
- `en` low for 100 cycles at `idx`=0x1234, using the truncated DUT → `op_a`/`op_b` hold 0x12/0x34. `done` at T0+65636, with statistics identical to the truncated case.
- `rst` at `idx`=1000 → all outputs 0, state IDLE. A second `start` gives complete, correct results. `start` pulses during RUN do not restart the sweep.
- Back-to-back runs: `start` in DONE with the DUT swapped from truncated to exact → accumulators cleared at restart. Final results are all 0 and `done` re-rises 65536 cycles later.

Source files
------------

// File: rtl/approx_adder_error_eval.sv
`default_nettype none
// ============================================================================
// Module   : approx_adder_error_eval
// Purpose  : Exhaustive error-evaluation harness for a combinational
//            WIDTH-bit approximate adder. Sweeps every operand pair,
//            compares the adder result against the exact sum and
//            accumulates error count, max |e|, sum |e|, signed sum e and
//            the first pair that reached the maximum error.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            start, en        - begin sweep (IDLE/DONE only), advance enable
//            op_a, op_b       - registered operands to the adder under test
//            approx_sum       - adder result (WIDTH+1 bits, combinational)
//            busy, done       - RUN / DONE state flags
//            err_count .. worst_b - registered error statistics
// Revision : 1.0 - initial release
// ============================================================================
module approx_adder_error_eval #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   en,
    output logic [WIDTH-1:0]       op_a,
    output logic [WIDTH-1:0]       op_b,
    input  logic [WIDTH:0]         approx_sum,
    output logic                   busy,
    output logic                   done,
    output logic [2*WIDTH:0]       err_count,
    output logic [WIDTH:0]         max_abs_err,
    output logic [3*WIDTH:0]       sum_abs_err,
    output logic signed [3*WIDTH+1:0] sum_err,
    output logic [WIDTH-1:0]       worst_a,
    output logic [WIDTH-1:0]       worst_b
);

    localparam int IW = 2 * WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic [IW-1:0]            r_idx;
    logic [2*WIDTH:0]         r_err_count;
    logic [WIDTH:0]           r_max_abs;
    logic [3*WIDTH:0]         r_sum_abs;
    logic signed [3*WIDTH+1:0] r_sum_err;
    logic [WIDTH-1:0]         r_worst_a;
    logic [WIDTH-1:0]         r_worst_b;

    logic [WIDTH:0]           w_exact;
    logic signed [WIDTH+1:0]  w_err;
    logic [WIDTH:0]           w_abs;
    logic                     w_nz;
    logic                     w_last;
    logic                     w_clear;
    logic                     w_step;

    // Operands come straight from the pair counter: A is the major index.
    assign op_a = r_idx[IW-1:WIDTH];
    assign op_b = r_idx[WIDTH-1:0];

    assign w_exact = {1'b0, op_a} + {1'b0, op_b};
    assign w_err   = $signed({1'b0, w_exact}) - $signed({1'b0, approx_sum});

    // |e| never exceeds 2^(WIDTH+1)-1, so the low WIDTH+1 bits of the
    // two's-complement negation are the full magnitude.
    assign w_abs = w_err[WIDTH+1] ? (~w_err[WIDTH:0] + {{WIDTH{1'b0}}, 1'b1})
                                  : w_err[WIDTH:0];
    assign w_nz  = |w_err;

    assign w_last  = &r_idx;
    assign w_clear = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_step  = (r_state == S_RUN) && en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_state_nxt = S_RUN;
            S_RUN:          if (en && w_last) w_state_nxt = S_DONE;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_idx       <= '0;
            r_err_count <= '0;
            r_max_abs   <= '0;
            r_sum_abs   <= '0;
            r_sum_err   <= '0;
            r_worst_a   <= '0;
            r_worst_b   <= '0;
        end else if (w_step) begin
            // Counter wraps to 0 on the last pair as the FSM enters DONE.
            r_idx       <= r_idx + {{(IW-1){1'b0}}, 1'b1};
            r_err_count <= r_err_count + {{(2*WIDTH){1'b0}}, w_nz};
            r_sum_abs   <= r_sum_abs + {{(2*WIDTH){1'b0}}, w_abs};
            r_sum_err   <= r_sum_err + {{(2*WIDTH){w_err[WIDTH+1]}}, w_err};
            // Strictly greater: ties keep the earliest pair.
            if (w_abs > r_max_abs) begin
                r_max_abs <= w_abs;
                r_worst_a <= op_a;
                r_worst_b <= op_b;
            end
        end
    end

    assign busy        = (r_state == S_RUN);
    assign done        = (r_state == S_DONE);
    assign err_count   = r_err_count;
    assign max_abs_err = r_max_abs;
    assign sum_abs_err = r_sum_abs;
    assign sum_err     = r_sum_err;
    assign worst_a     = r_worst_a;
    assign worst_b     = r_worst_b;

endmodule
`default_nettype wire

// File: tb/tb_approx_adder_error_eval.sv
`default_nettype none
// ============================================================================
// Module   : tb_approx_adder_error_eval
// Purpose  : Self-checking bench for approx_adder_error_eval. A WIDTH=4
//            instance covers exact / truncated / stuck-at-zero adders,
//            reset mid-sweep, start pulses during RUN and restart from
//            DONE; a WIDTH=8 instance runs the full 65536-pair truncated
//            sweep with a 100-cycle enable stall at pair 0x1234.
//            Expected statistics are pushed into a queue when a sweep is
//            launched and popped by a monitor when done rises.
// Revision : 1.0 - initial release
// ============================================================================
module tb_approx_adder_error_eval;

    typedef struct {
        int cnt;
        int mx;
        int sabs;
        int serr;
        int wa;
        int wb;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_c;
    logic en_c;
    logic sel;      // 0: WIDTH=4 instance, 1: WIDTH=8 instance
    int   mode4;
    int   mode8;
    logic start4;
    logic start8;

    assign start4 = start_c & ~sel;
    assign start8 = start_c & sel;

    logic [3:0]         op_a4, op_b4, wa4, wb4;
    logic [4:0]         approx4, max4;
    logic               busy4, done4;
    logic [8:0]         cnt4;
    logic [12:0]        sabs4;
    logic signed [13:0] serr4;

    logic [7:0]         op_a8, op_b8, wa8, wb8;
    logic [8:0]         approx8, max8;
    logic               busy8, done8;
    logic [16:0]        cnt8;
    logic [24:0]        sabs8;
    logic signed [25:0] serr8;

    // Behavioural adders under test: 0 exact, 1 truncated low 3 bits, 2 stuck at 0
    function automatic int model(input int a, input int b, input int m);
        case (m)
            0:       return a + b;
            1:       return (a + b) & ~7;
            default: return 0;
        endcase
    endfunction

    assign approx4 = 5'(model(int'(op_a4), int'(op_b4), mode4));
    assign approx8 = 9'(model(int'(op_a8), int'(op_b8), mode8));

    approx_adder_error_eval #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .en(en_c),
        .op_a(op_a4), .op_b(op_b4), .approx_sum(approx4),
        .busy(busy4), .done(done4), .err_count(cnt4), .max_abs_err(max4),
        .sum_abs_err(sabs4), .sum_err(serr4), .worst_a(wa4), .worst_b(wb4)
    );

    approx_adder_error_eval #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .en(en_c),
        .op_a(op_a8), .op_b(op_b8), .approx_sum(approx8),
        .busy(busy8), .done(done8), .err_count(cnt8), .max_abs_err(max8),
        .sum_abs_err(sabs8), .sum_err(serr8), .worst_a(wa8), .worst_b(wb8)
    );

    // Views of whichever instance is selected
    int cur_idx, cur_busy, cur_done, cur_opa, cur_opb;
    int cur_cnt, cur_max, cur_sabs, cur_serr, cur_wa, cur_wb;
    assign cur_idx  = sel ? int'({op_a8, op_b8}) : int'({op_a4, op_b4});
    assign cur_busy = sel ? int'(busy8) : int'(busy4);
    assign cur_done = sel ? int'(done8) : int'(done4);
    assign cur_opa  = sel ? int'(op_a8) : int'(op_a4);
    assign cur_opb  = sel ? int'(op_b8) : int'(op_b4);
    assign cur_cnt  = sel ? int'(cnt8)  : int'(cnt4);
    assign cur_max  = sel ? int'(max8)  : int'(max4);
    assign cur_sabs = sel ? int'(sabs8) : int'(sabs4);
    assign cur_serr = sel ? int'(serr8) : int'(serr4);
    assign cur_wa   = sel ? int'(wa8)   : int'(wa4);
    assign cur_wb   = sel ? int'(wb8)   : int'(wb4);

    int   n_vec = 0;
    int   n_err = 0;
    exp_t q4[$];
    exp_t q8[$];
    exp_t e4, e8;
    bit   dq4 = 1'b0;
    bit   dq8 = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int c, input int m, input int sa,
                                input int se, input int a, input int b);
        exp_t e;
        e.cnt = c; e.mx = m; e.sabs = sa; e.serr = se; e.wa = a; e.wb = b;
        return e;
    endfunction

    // Monitors: compare final statistics whenever done rises
    initial begin
        forever begin
            @(posedge clk); #1;
            if (done4 && !dq4) begin
                if (q4.size() == 0) begin
                    chk("w4_unexpected_done", 1, 0);
                end else begin
                    e4 = q4.pop_front();
                    chk("w4_err_count",   int'(cnt4),  e4.cnt);
                    chk("w4_max_abs_err", int'(max4),  e4.mx);
                    chk("w4_sum_abs_err", int'(sabs4), e4.sabs);
                    chk("w4_sum_err",     int'(serr4), e4.serr);
                    chk("w4_worst_a",     int'(wa4),   e4.wa);
                    chk("w4_worst_b",     int'(wb4),   e4.wb);
                end
            end
            dq4 = done4;
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (done8 && !dq8) begin
                if (q8.size() == 0) begin
                    chk("w8_unexpected_done", 1, 0);
                end else begin
                    e8 = q8.pop_front();
                    chk("w8_err_count",   int'(cnt8),  e8.cnt);
                    chk("w8_max_abs_err", int'(max8),  e8.mx);
                    chk("w8_sum_abs_err", int'(sabs8), e8.sabs);
                    chk("w8_sum_err",     int'(serr8), e8.serr);
                    chk("w8_worst_a",     int'(wa8),   e8.wa);
                    chk("w8_worst_b",     int'(wb8),   e8.wb);
                end
            end
            dq8 = done8;
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},  cur_busy, 0);
        chk({tag, "_done"},  cur_done, 0);
        chk({tag, "_op_a"},  cur_opa,  0);
        chk({tag, "_op_b"},  cur_opb,  0);
        chk({tag, "_cnt"},   cur_cnt,  0);
        chk({tag, "_max"},   cur_max,  0);
        chk({tag, "_sabs"},  cur_sabs, 0);
        chk({tag, "_serr"},  cur_serr, 0);
        chk({tag, "_wa"},    cur_wa,   0);
        chk({tag, "_wb"},    cur_wb,   0);
    endtask

    // Launch one sweep on the selected instance. Negative pause_at /
    // inj_at / abort_at disable the stall, the mid-run start pulse and the
    // mid-run reset respectively.
    task automatic do_run(input string tag, input int mode, input exp_t e,
                          input int exp_lat, input int pause_at,
                          input int pause_len, input int inj_at,
                          input int abort_at);
        int cycles = 0;
        int paused = 0;
        bit pz;
        if (sel) mode8 = mode; else mode4 = mode;
        if (abort_at < 0) begin
            if (sel) q8.push_back(e); else q4.push_back(e);
        end
        @(negedge clk);
        start_c = 1'b1;
        en_c    = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_busy_at_start"}, cur_busy, 1);
        chk({tag, "_done_at_start"}, cur_done, 0);
        chk({tag, "_idx_at_start"},  cur_idx,  0);
        chk({tag, "_cleared"},       cur_cnt + cur_max + cur_sabs, 0);
        forever begin
            @(negedge clk);
            start_c = 1'b0;
            if (cur_done != 0) break;
            if (cycles > exp_lat + 10) begin
                chk({tag, "_timeout_cycles"}, cycles, exp_lat);
                break;
            end
            if (cur_idx == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                chk_zero({tag, "_after_rst"});
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            pz   = (cur_idx == pause_at) && (paused < pause_len);
            en_c = !pz;
            if (pz) paused++;
            if (cycles == inj_at) start_c = 1'b1;
            @(posedge clk); #1;
            cycles++;
            if (pz && paused == pause_len) begin
                chk({tag, "_hold_op_a"}, cur_opa, sel ? (pause_at >> 8) : (pause_at >> 4) & 15);
                chk({tag, "_hold_op_b"}, cur_opb, sel ? (pause_at & 255) : (pause_at & 15));
            end
        end
        en_c = 1'b1;
        chk({tag, "_latency"},      cycles,   exp_lat);
        chk({tag, "_busy_at_done"}, cur_busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst     = 1'b1;
        start_c = 1'b1;     // reset must override start and en
        en_c    = 1'b1;
        sel     = 1'b0;
        mode4   = 0;
        mode8   = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset_w4");
        sel = 1'b1;
        #1;
        chk_zero("reset_w8");
        sel = 1'b0;
        @(negedge clk);
        rst     = 1'b0;
        start_c = 1'b0;

        do_run("w4_exact", 0, mk(0, 0, 0, 0, 0, 0),            256, -1, 0, -1, -1);
        do_run("w4_trunc", 1, mk(224, 7, 896, 896, 0, 7),      256, -1, 0, -1, -1);
        do_run("w4_stuck", 2, mk(255, 30, 3840, 3840, 15, 15), 256, -1, 0, -1, -1);
        do_run("w4_abort", 1, mk(0, 0, 0, 0, 0, 0),            256, -1, 0, -1, 100);
        do_run("w4_trunc2", 1, mk(224, 7, 896, 896, 0, 7),     256, -1, 0, 50, -1);
        do_run("w4_b2b_exact", 0, mk(0, 0, 0, 0, 0, 0),        256, -1, 0, -1, -1);

        sel = 1'b1;
        do_run("w8_trunc_pause", 1, mk(57344, 7, 229376, 229376, 0, 7),
               65636, 'h1234, 100, 500, -1);

        repeat (3) @(posedge clk);
        #1;
        chk("queues_drained", q4.size() + q8.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
